shift_sequencer: RTL and testbench

//  Multi-cycle shift/rotate/bit-reverse unit for the execute stage. Holds one
//  1-bit-per-cycle right-shift datapath plus the 16b bit-reversal network.

---
 rtl/shift_sequencer.sv | 113 +++++++++++
 tb/tb_shift_sequencer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle 16b shift/rotate/bit-reverse unit with valid/ready request and response.
module shift_sequencer #(
    parameter int DATA_W  = 16,
    parameter int SHAMT_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [2:0]         req_op,
    input  logic [DATA_W-1:0]  req_data,
    input  logic [SHAMT_W-1:0] req_shamt,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_W-1:0]  rsp_data,
    output logic               rsp_err,
    output logic               busy
);
    typedef enum logic [2:0] {IDLE, PRE, SHIFT, POST, DONE} state_t;
    localparam logic [2:0] SLL = 3'b000, SRA = 3'b010, ROL = 3'b011, ROR = 3'b100, REV = 3'b101;

    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [DATA_W-1:0]  data_q, data_d, acc_q, acc_d, rsp_data_q, rsp_data_d;
    logic [SHAMT_W-1:0] shamt_q, shamt_d, cnt_q, cnt_d;
    logic               sign_q, sign_d, rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic               is_left, illegal, fill;

    function automatic logic [DATA_W-1:0] rev(input logic [DATA_W-1:0] v);
        for (int i = 0; i < DATA_W; i++) rev[i] = v[DATA_W-1-i];
    endfunction

    assign is_left   = (op_q == SLL) || (op_q == ROL);
    assign illegal   = op_q[2:1] == 2'b11;
    assign fill      = (op_q == SRA) ? sign_q : (op_q == ROL || op_q == ROR) ? acc_q[0] : 1'b0;
    assign req_ready = state_q == IDLE;
    assign busy      = state_q != IDLE;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        data_d      = data_q;
        shamt_d     = shamt_q;
        sign_d      = sign_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: if (req_valid) begin
                op_d    = req_op;
                data_d  = req_data;
                shamt_d = req_shamt;
                sign_d  = req_data[DATA_W-1];
                state_d = PRE;
            end
            PRE: begin
                acc_d   = (is_left || op_q == REV) ? rev(data_q) : data_q;
                cnt_d   = (op_q == REV || illegal) ? '0 : shamt_q;
                state_d = (cnt_d != '0) ? SHIFT : POST;
            end
            SHIFT: begin
                acc_d   = {fill, acc_q[DATA_W-1:1]};
                cnt_d   = cnt_q - 1'b1;
                state_d = (cnt_q == 1) ? POST : SHIFT;
            end
            POST: begin
                acc_d       = is_left ? rev(acc_q) : acc_q;
                rsp_valid_d = 1'b1;
                rsp_data_d  = acc_d;
                rsp_err_d   = illegal;
                state_d     = DONE;
            end
            DONE: if (rsp_ready) begin
                rsp_valid_d = 1'b0;
                rsp_data_d  = '0;
                rsp_err_d   = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= '0;
            data_q      <= '0;
            shamt_q     <= '0;
            sign_q      <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            data_q      <= data_d;
            shamt_q     <= shamt_d;
            sign_q      <= sign_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed scoreboard bench for shift_sequencer.
module tb_shift_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = '0;
    logic [15:0] req_data = '0;
    logic [3:0]  req_shamt = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        busy;

    typedef struct {
        logic [15:0] data;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sb[$];
    int   compared = 0;
    int   mismatched = 0;

    shift_sequencer dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_data(req_data), .req_shamt(req_shamt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one request, push its expectation, return once the accept edge has passed.
    task automatic send(input logic [2:0] op, input logic [15:0] d, input logic [3:0] sh,
                        input logic [15:0] exp_d, input logic exp_e, input int lat);
        int w;
        sb.push_back('{exp_d, exp_e, lat});
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_data  = d;
        req_shamt = sh;
        w = 0;
        while (!req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("accept_wait", 32'(w < 50), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Called #1 after the accept edge; counts cycles until rsp_valid then compares against the scoreboard.
    task automatic wait_rsp(input string tag);
        int   n;
        exp_t e;
        n = 1;
        while (!rsp_valid && n < 40) begin
            @(posedge clk);
            #1 n++;
        end
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_lat"}, 32'(n), 32'(e.lat));
            chk({tag, "_data"}, {16'd0, rsp_data}, {16'd0, e.data});
            chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, e.err});
        end
    endtask

    task automatic release_rsp(input string tag);
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        chk({tag, "_idle_ready"}, {31'd0, req_ready}, 32'd1);
        chk({tag, "_idle_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_idle_data"}, {16'd0, rsp_data}, 32'd0);
    endtask

    task automatic op(input string tag, input logic [2:0] o, input logic [15:0] d, input logic [3:0] sh,
                      input logic [15:0] exp_d, input logic exp_e, input int lat);
        send(o, d, sh, exp_d, exp_e, lat);
        wait_rsp(tag);
        release_rsp(tag);
    endtask

    initial begin
        logic [15:0] held;
        int          seen;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_data", {16'd0, rsp_data}, 32'd0);
        chk("rst_err", {31'd0, rsp_err}, 32'd0);
        rst_n = 1'b1;

        op("sll15", 3'b000, 16'h0001, 4'd15, 16'h8000, 1'b0, 18);
        op("sra4",  3'b010, 16'h8000, 4'd4,  16'hF800, 1'b0, 7);
        op("srl4",  3'b001, 16'h8000, 4'd4,  16'h0800, 1'b0, 7);
        op("rol1",  3'b011, 16'h8001, 4'd1,  16'h0003, 1'b0, 4);
        op("ror1",  3'b100, 16'h0001, 4'd1,  16'h8000, 1'b0, 4);
        op("rev",   3'b101, 16'h0001, 4'd7,  16'h8000, 1'b0, 3);
        op("srl0",  3'b001, 16'h1234, 4'd0,  16'h1234, 1'b0, 3);
        op("ill6",  3'b110, 16'hBEEF, 4'd5,  16'hBEEF, 1'b1, 3);
        op("ill7",  3'b111, 16'h0F0F, 4'd9,  16'h0F0F, 1'b1, 3);
        op("sll0",  3'b000, 16'hA5C3, 4'd0,  16'hA5C3, 1'b0, 3);
        op("sll4",  3'b000, 16'h1234, 4'd4,  16'h2340, 1'b0, 7);
        op("sra3p", 3'b010, 16'h7F00, 4'd3,  16'h0FE0, 1'b0, 6);
        op("rol4",  3'b011, 16'h1234, 4'd4,  16'h2341, 1'b0, 7);
        op("ror15", 3'b100, 16'h8001, 4'd15, 16'h0003, 1'b0, 18);

        // Backpressure: result held, a pending request must not be accepted.
        send(3'b010, 16'hC003, 4'd2, 16'hF000, 1'b0, 5);
        wait_rsp("bp");
        held = rsp_data;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 3'b001;
        req_data  = 16'h00F0;
        req_shamt = 4'd4;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_data", {16'd0, rsp_data}, {16'd0, held});
            chk("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_no_ready", {31'd0, req_ready}, 32'd0);
        end
        req_valid = 1'b0;
        release_rsp("bp");

        // Reset mid-SHIFT drops the operation with no response.
        send(3'b000, 16'h0001, 4'd10, 16'h0400, 1'b0, 13);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        void'(sb.pop_back());
        chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1 if (rsp_valid) seen++;
        end
        chk("mid_rst_no_rsp", 32'(seen), 32'd0);
        op("after_rst", 3'b001, 16'hF00F, 4'd8, 16'h00F0, 1'b0, 11);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
